// File: rtl/analog_switch_driver.sv
// -----------------------------------------------------------------------------
// analog_switch_driver
//
// Drives the integrator front-end input switches (SHORT, INPUT, REF_POS,
// REF_NEG) from sequencer requests. Every change of selection opens all
// switches for DEAD_CYCLES cycles (break-before-make). The new selection is
// then held for MIN_HOLD cycles before another request is taken. Saturation
// or loss of the reference forces the block back to the SHORT safe state.
//
// Ports
//   clk_i        system clock
//   rst_i        asynchronous reset, active-low
//   sel_i        requested selection: 0 SHORT, 1 INPUT, 2 REF_POS, 3 REF_NEG
//   sel_valid_i  request valid
//   sel_ready_o  request accepted when sel_valid_i & sel_ready_o (high in IDLE)
//   sat_hi_i     sanitized integrator high-saturation flag
//   sat_lo_i     sanitized integrator low-saturation flag
//   ref_ok_i     sanitized reference-ready flag
//   sw_o         one-hot switch enables; all-zero only during dead time
//   cur_sel_o    selection applied, or targeted while in dead time
//   done_o       one-cycle pulse when a selection has settled
//   reject_o     one-cycle pulse when a request is refused
//   sat_abort_o  sticky: saturation forced SHORT
//   ref_fault_o  sticky: reference loss forced SHORT
// -----------------------------------------------------------------------------
module analog_switch_driver #(
    parameter int DEAD_CYCLES = 4,
    parameter int MIN_HOLD    = 8,
    parameter int CNT_WIDTH   = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] sel_i,
    input  logic       sel_valid_i,
    output logic       sel_ready_o,
    input  logic       sat_hi_i,
    input  logic       sat_lo_i,
    input  logic       ref_ok_i,
    output logic [3:0] sw_o,
    output logic [1:0] cur_sel_o,
    output logic       done_o,
    output logic       reject_o,
    output logic       sat_abort_o,
    output logic       ref_fault_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DEAD = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [1:0]           SEL_SHORT = 2'd0;
    localparam logic [CNT_WIDTH-1:0] DEAD_LAST = CNT_WIDTH'(DEAD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(MIN_HOLD - 1);

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]           sel_q, sel_d;
    logic                 done_q, done_d;
    logic                 reject_q, reject_d;
    logic                 sat_q, sat_d;
    logic                 ref_q, ref_d;

    logic accept;
    logic sat_cause;
    logic ref_cause;
    logic abort;

    // sel_q is the applied selection in IDLE/HOLD and the target in DEAD,
    // so one compare covers both "applied or target".
    assign accept    = sel_valid_i && (state_q == ST_IDLE);
    assign sat_cause = (sat_hi_i || sat_lo_i) && (sel_q != SEL_SHORT);
    assign ref_cause = !ref_ok_i && sel_q[1];
    assign abort     = sat_cause || ref_cause;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sel_q    <= SEL_SHORT;
            done_q   <= 1'b0;
            reject_q <= 1'b0;
            sat_q    <= 1'b0;
            ref_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            done_q   <= done_d;
            reject_q <= reject_d;
            sat_q    <= sat_d;
            ref_q    <= ref_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        done_d   = 1'b0;
        reject_d = 1'b0;
        sat_d    = sat_q;
        ref_d    = ref_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sat_d = 1'b0;
                    ref_d = 1'b0;
                    if (sel_i[1] && !ref_ok_i) begin
                        reject_d = 1'b1;
                    end else if (sel_i == sel_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_DEAD;
                        cnt_d   = '0;
                        sel_d   = sel_i;
                    end
                end
            end
            ST_DEAD: begin
                if (cnt_q == DEAD_LAST) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                sel_d   = SEL_SHORT;
            end
        endcase

        // Abort overrides everything above. A same-cycle request is discarded
        // (so the stickies are not cleared by it) and reported as rejected.
        // Inside DEAD only the target changes; the dead-time count runs on.
        if (abort) begin
            sel_d    = SEL_SHORT;
            sat_d    = sat_q | sat_cause;
            ref_d    = ref_q | ref_cause;
            done_d   = 1'b0;
            reject_d = accept;
            if (state_q != ST_DEAD) begin
                state_d = ST_DEAD;
                cnt_d   = '0;
            end
        end
    end

    assign sw_o        = (state_q == ST_DEAD) ? 4'b0000 : (4'b0001 << sel_q);
    assign cur_sel_o   = sel_q;
    assign sel_ready_o = (state_q == ST_IDLE);
    assign done_o      = done_q;
    assign reject_o    = reject_q;
    assign sat_abort_o = sat_q;
    assign ref_fault_o = ref_q;

endmodule

// File: tb/tb_analog_switch_driver.sv
module tb_analog_switch_driver;

    logic       clk;
    logic       rst_i;
    logic [1:0] sel;
    logic       sel_valid;
    logic       sel_ready;
    logic       sat_hi;
    logic       sat_lo;
    logic       ref_ok;
    logic [3:0] sw;
    logic [1:0] cur_sel;
    logic       done;
    logic       reject;
    logic       sat_abort;
    logic       ref_fault;

    int checks = 0;
    int errors = 0;

    analog_switch_driver #(
        .DEAD_CYCLES(4),
        .MIN_HOLD   (8),
        .CNT_WIDTH  (8)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .sel_i      (sel),
        .sel_valid_i(sel_valid),
        .sel_ready_o(sel_ready),
        .sat_hi_i   (sat_hi),
        .sat_lo_i   (sat_lo),
        .ref_ok_i   (ref_ok),
        .sw_o       (sw),
        .cur_sel_o  (cur_sel),
        .done_o     (done),
        .reject_o   (reject),
        .sat_abort_o(sat_abort),
        .ref_fault_o(ref_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {sw, cur_sel, ready, done, reject, sat_abort, ref_fault}
    logic [10:0] obs;
    assign obs = {sw, cur_sel, sel_ready, done, reject, sat_abort, ref_fault};

    function automatic logic [10:0] ex(input logic [3:0] s, input logic [1:0] cs,
                                       input logic rdy, input logic dn, input logic rj,
                                       input logic sa, input logic rf);
        return {s, cs, rdy, dn, rj, sa, rf};
    endfunction

    task automatic test_reset();
        logic [10:0] e;
        rst_i = 1'b0; sel = 2'd0; sel_valid = 1'b0;
        sat_hi = 1'b0; sat_lo = 1'b0; ref_ok = 1'b1;
        #12;
        e = ex(4'b0001, 2'd0, 1, 0, 0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_values got=%b exp=%b", obs, e);
        end
        @(negedge clk);
        rst_i = 1'b1;
    endtask

    // SHORT -> INPUT: 4 dead cycles, 8 hold cycles, done at accept+13
    task automatic test_input();
        logic [10:0] e;
        @(negedge clk);
        e = ex(4'b0001, 2'd0, 1, 0, 0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL input_pre got=%b exp=%b", obs, e);
        end
        sel = 2'd1; sel_valid = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            sel_valid = 1'b0;
            e = ex((k <= 4) ? 4'b0000 : 4'b0010, 2'd1, k >= 13, k == 13, 0, 0, 0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL input_seq k=%0d got=%b exp=%b", k, obs, e);
            end
        end
    endtask

    // REF_POS while reference not ready: refused, switches untouched
    task automatic test_reject();
        logic [10:0] e;
        @(negedge clk);
        ref_ok = 1'b0; sel = 2'd2; sel_valid = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            sel_valid = 1'b0;
            e = ex(4'b0010, 2'd1, 1, 0, k == 1, 0, 0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reject_ref k=%0d got=%b exp=%b", k, obs, e);
            end
        end
        ref_ok = 1'b1;
    endtask

    // INPUT -> REF_NEG, with a one-hot check every cycle
    task automatic test_ref_neg();
        logic [10:0] e;
        @(negedge clk);
        sel = 2'd3; sel_valid = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            sel_valid = 1'b0;
            e = ex((k <= 4) ? 4'b0000 : 4'b1000, 2'd3, k >= 13, k == 13, 0, 0, 0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL refneg_seq k=%0d got=%b exp=%b", k, obs, e);
            end
            checks++;
            if ($countones(sw) > 1) begin
                errors++;
                $display("FAIL refneg_onehot k=%0d got=%b exp=at most one bit", k, sw);
            end
        end
    endtask

    // REF_NEG -> INPUT, sat_hi pulse in HOLD forces SHORT; sticky until next accept
    task automatic test_sat_abort();
        logic [10:0] e;
        logic [3:0]  s;
        logic [1:0]  cs;
        @(negedge clk);
        sel = 2'd1; sel_valid = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            sel_valid = 1'b0;
            if (k <= 4)       begin s = 4'b0000; cs = 2'd1; end
            else if (k <= 6)  begin s = 4'b0010; cs = 2'd1; end
            else if (k <= 10) begin s = 4'b0000; cs = 2'd0; end
            else              begin s = 4'b0001; cs = 2'd0; end
            e = ex(s, cs, k >= 19, k == 19, 0, k >= 7, 0);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL sat_abort k=%0d got=%b exp=%b", k, obs, e);
            end
            sat_hi = (k == 6);
        end
        // Same-selection request: done next cycle, sticky cleared
        sel = 2'd0; sel_valid = 1'b1;
        @(negedge clk);
        sel_valid = 1'b0;
        e = ex(4'b0001, 2'd0, 1, 1, 0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL same_sel_clear got=%b exp=%b", obs, e);
        end
    endtask

    // SHORT -> REF_POS, ref lost in DEAD: retarget SHORT, dead count not restarted
    task automatic test_ref_drop_dead();
        logic [10:0] e;
        @(negedge clk);
        sel = 2'd2; sel_valid = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            sel_valid = 1'b0;
            e = ex((k <= 4) ? 4'b0000 : 4'b0001, (k <= 2) ? 2'd2 : 2'd0,
                   k >= 13, k == 13, 0, 0, k >= 3);
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL ref_drop k=%0d got=%b exp=%b", k, obs, e);
            end
            if (k == 2) ref_ok = 1'b0;
        end
        ref_ok = 1'b1;
    endtask

    // Abort coinciding with a handshake in IDLE: request discarded and rejected
    task automatic test_abort_vs_request();
        logic [10:0] e;
        @(negedge clk);
        sel = 2'd1; sel_valid = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            sel_valid = 1'b0;
        end
        e = ex(4'b0010, 2'd1, 1, 1, 0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL abort_req_setup got=%b exp=%b", obs, e);
        end
        sat_hi = 1'b1; sel = 2'd3; sel_valid = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            sel_valid = 1'b0;
            sat_hi = 1'b0;
            if (k <= 2 || k == 5 || k == 13) begin
                e = ex((k <= 4) ? 4'b0000 : 4'b0001, 2'd0, k >= 13, k == 13, k == 1, 1, 0);
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL abort_req k=%0d got=%b exp=%b", k, obs, e);
                end
            end
        end
    endtask

    // Asynchronous reset asserted mid-DEAD with a sticky set
    task automatic test_reset_in_dead();
        logic [10:0] e;
        @(negedge clk);
        sel = 2'd2; sel_valid = 1'b1;
        @(negedge clk);
        sel_valid = 1'b0;
        e = ex(4'b0000, 2'd2, 0, 0, 0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL rst_dead_pre got=%b exp=%b", obs, e);
        end
        sat_lo = 1'b1;
        @(negedge clk);
        sat_lo = 1'b0;
        e = ex(4'b0000, 2'd0, 0, 0, 0, 1, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL rst_dead_abort got=%b exp=%b", obs, e);
        end
        #2;
        rst_i = 1'b0;
        #1;
        e = ex(4'b0001, 2'd0, 1, 0, 0, 0, 0);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL rst_dead_async got=%b exp=%b", obs, e);
        end
        @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL rst_dead_after got=%b exp=%b", obs, e);
        end
    endtask

    initial begin
        test_reset();
        test_input();
        test_reject();
        test_ref_neg();
        test_sat_abort();
        test_ref_drop_dead();
        test_abort_vs_request();
        test_reset_in_dead();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
